// File: rtl/restoring_divider_if.sv
// Handshake and result bundle for the restoring divider.
// The requester uses the master modport and the divider uses the slave modport.
interface restoring_divider_if #(
    parameter int WIDTH = 9
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_zero;

    modport master (
        output start, x, y,
        input  busy, done, q, r, div_zero
    );

    modport slave (
        input  start, x, y,
        output busy, done, q, r, div_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// Unsigned restoring divider that produces one quotient bit per clock.
// A request is accepted in IDLE. CALC then runs WIDTH shift/subtract steps,
// and done pulses in the cycle after the last step.
// A zero divisor is flagged after the first CALC edge.
module restoring_divider #(
    parameter int WIDTH = 9
) (
    input  logic                clk,
    input  logic                rst,
    restoring_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] y_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             done_reg;
    logic             dz_reg;
    logic             accept;
    logic             last_step;
    logic             zero_div;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;

    // One restoring step. Shift {rem, quo} left and try to subtract the divisor.
    // The working remainder always stays below the divisor, so the trial result
    // fits in WIDTH+1 signed bits and its top bit acts as the borrow.
    function automatic logic [2*WIDTH:0] restore_step(
        input logic [WIDTH:0]   rem_i,
        input logic [WIDTH-1:0] quo_i,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0]        shifted;
        logic signed [WIDTH:0] trial;
        logic [WIDTH:0]        rem_o;
        logic [WIDTH-1:0]      quo_o;
        shifted = (rem_i << 1) | {{WIDTH{1'b0}}, quo_i[WIDTH-1]};
        trial   = $signed(shifted - {1'b0, d});
        quo_o   = quo_i << 1;
        if (trial[WIDTH] == 1'b0) begin
            rem_o    = $unsigned(trial);
            quo_o[0] = 1'b1;
        end else begin
            rem_o    = shifted;
        end
        return {rem_o, quo_o};
    endfunction

    // Next-step datapath values for the current working registers
    always_comb begin
        {rem_n, quo_n} = restore_step(rem, quo, y_reg);
    end

    // Next-state logic and per-cycle control decisions
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        last_step = 1'b0;
        zero_div  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (cnt == '0 && y_reg == '0) begin
                    zero_div = 1'b1;
                    state_n  = IDLE;
                end else if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_step = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Working registers, iteration counter and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            y_reg    <= '0;
            cnt      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                y_reg  <= bus.y;
                rem    <= '0;
                quo    <= bus.x;
                cnt    <= '0;
                dz_reg <= 1'b0;
            end else if (state == CALC) begin
                if (zero_div) begin
                    // quo still holds the untouched dividend here
                    q_reg    <= '1;
                    r_reg    <= quo;
                    dz_reg   <= 1'b1;
                    done_reg <= 1'b1;
                end else begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        q_reg    <= quo_n;
                        r_reg    <= rem_n[WIDTH-1:0];
                        done_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.busy     = (state == CALC);
    assign bus.done     = done_reg;
    assign bus.q        = q_reg;
    assign bus.r        = r_reg;
    assign bus.div_zero = dz_reg;
endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter: WIDTH, default 9, operand/result width in bits.
REQ-002 The block SHALL have one clock, and reset SHALL be asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-006 x  input  WIDTH  unsigned dividend; sampled only on the accepting edge.
REQ-007 y  input  WIDTH  unsigned divisor; sampled only on the accepting edge.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse; q, r and div_zero are valid from this cycle.
REQ-010 q  output  WIDTH  quotient, registered.
REQ-011 r  output  WIDTH  remainder, registered.
REQ-012 div_zero  output  1  set when the last accepted divisor was zero.

Function
REQ-013 The FSM SHALL have two states: IDLE and CALC.
REQ-014 IDLE with start=1 SHALL accept the request at that edge (E0):
- latch y;
- load working remainder = 0 and working quotient = x;
- clear the iteration counter;
- busy=1; clear div_zero; go to CALC.
REQ-015 The working remainder SHALL be WIDTH+1 bits wide so that the trial subtraction never overflows.
REQ-016 Each CALC edge SHALL perform one restoring step:
- shift {rem, quo} left by one bit;
- trial = rem - y, computed at WIDTH+1 bits;
- if trial is non-negative: rem = trial, quo[0] = 1;
- otherwise: rem is unchanged, quo[0] = 0.
REQ-017 After exactly WIDTH CALC steps (edges E1..E_WIDTH), at edge E_WIDTH the block SHALL:
- load q and r;
- assert done for exactly one cycle;
- set busy=0; return to IDLE.
REQ-018 Latency SHALL be WIDTH cycles from the accepting edge to done (9 for the default WIDTH).
REQ-019 Divisor zero: at edge E1 the block SHALL:
- set q = all ones and r = x;
- set div_zero=1 and done=1; set busy=0;
- return to IDLE (latency 1).
REQ-020 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-021 start during the cycle in which done=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-022 q, r and div_zero SHALL hold their values until the next completion; q and r SHALL not change during CALC.
REQ-023 All arithmetic SHALL be unsigned.
REQ-024 The results SHALL satisfy x = q*y + r and r < y whenever y != 0.
REQ-025 Input changes outside the accepting edge SHALL not affect the result.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE; busy=0, done=0, div_zero=0; q=0, r=0; working registers and counter cleared.
REQ-027 rst asserted mid-operation SHALL abort the division, with no done pulse after release.
REQ-028 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-029 x=100, y=7, start for 1 cycle -> busy high for 9 cycles; then done=1 with q=14, r=2, div_zero=0.
REQ-030 x=511, y=1 -> q=511, r=0. x=5, y=9 -> q=0, r=5. x=511, y=511 -> q=1, r=0.
REQ-031 x=300, y=0 -> one cycle later: done=1, q=511, r=300, div_zero=1. Then x=20, y=4 -> q=5, r=0, div_zero cleared.
REQ-032 Start 200/3, then pulse start with 50/5 at cycle 4 -> ignored; result q=66, r=2 at cycle 9.
REQ-033 Start 255/2, assert rst at cycle 5 -> outputs 0 immediately, no done pulse. After release, 9/4 -> q=2, r=1.
REQ-034 Back-to-back: start held high through done -> second operation begins in the done cycle with no idle gap; random sweep checked against x = q*y + r.
